// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Brings a PLL out of reset, waits for a stable lock and then
//               releases the PLL-clocked core. Retries on lock timeout,
//               re-sequences on lock loss, and reports status.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 256,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       lock_clear,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_PLLRST   = 2'd0,
    S_WAITLOCK = 2'd1,
    S_SETTLE   = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  // Terminal counts for each timed state (counter runs 0..N-1).
  localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_lock_last   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_lock_s;
  logic             r_pll_resetb;
  logic             r_sys_reset;
  logic             r_ready;
  logic             r_lock_lost;
  logic [7:0]       r_retry;
  logic             w_timeout;
  logic             w_lock_drop;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  // Next-state decode; lock takes priority over the timeout in WAITLOCK.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_lock_drop  = 1'b0;
    case (r_state)
      S_PLLRST: begin
        if (r_cnt == c_rst_last) w_next_state = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (r_lock_s) begin
          w_next_state = S_SETTLE;
        end else if (r_cnt == c_lock_last) begin
          w_next_state = S_PLLRST;
          w_timeout    = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!r_lock_s)                   w_next_state = S_WAITLOCK;
        else if (r_cnt == c_settle_last) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_next_state = S_PLLRST;
          w_lock_drop  = 1'b1;
        end
      end
      default: w_next_state = S_PLLRST;
    endcase
  end

  // State register and shared counter, cleared on every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_PLLRST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pll_resetb <= 1'b0;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_pll_resetb <= (w_next_state != S_PLLRST);
      r_sys_reset  <= (w_next_state != S_RUN);
      r_ready      <= (w_next_state == S_RUN);
    end
  end

  // Sticky lock-loss flag (set beats clear) and saturating timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_lost <= 1'b0;
      r_retry     <= 8'd0;
    end else begin
      if (w_lock_drop)     r_lock_lost <= 1'b1;
      else if (lock_clear) r_lock_lost <= 1'b0;
      if (w_timeout && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
    end
  end

  assign pll_resetb  = r_pll_resetb;
  assign sys_reset   = r_sys_reset;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed self-checking bench for pll_reset_sequencer using
//               RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       lock_clear;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .SETTLE_CYCLES(8),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .lock_clear (lock_clear),
    .pll_resetb (pll_resetb),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for a given state; callers check the state afterwards.
  task automatic wait_state(input logic [1:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Hold reset for one edge, release it 1 unit after a rising edge.
  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_lock = 1'b1; lock_clear = 1'b0;
    tick_n(2);
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL reset_pll_resetb: got %b want 0", pll_resetb); end
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL reset_sys_reset: got %b want 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
  endtask

  task automatic test_lock_up();
    int n_low, first_high, ready_edge;
    n_low = 0; first_high = -1; ready_edge = -1;
    reset = 1'b0;
    if (pll_resetb === 1'b0) n_low++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (first_high < 0) begin
        if (pll_resetb === 1'b0) n_low++;
        else first_high = k;
      end
      if (ready === 1'b1 && ready_edge < 0) ready_edge = k;
    end
    checks++; if (n_low !== 4) begin errors++; $display("FAIL lockup_resetb_low_cycles: got %0d want 4", n_low); end
    checks++; if (ready_edge < 13 || ready_edge > 15) begin errors++; $display("FAIL lockup_ready_latency: got %0d want 13..15", ready_edge); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL lockup_retry: got %0d want 0", retry_count); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL lockup_state: got %0d want 3", state); end
    checks++; if (sys_reset !== 1'b0) begin errors++; $display("FAIL lockup_sys_reset: got %b want 0", sys_reset); end
  endtask

  task automatic test_lock_loss();
    // One-cycle lock drop with lock_clear held high across the set edge.
    pll_lock = 1'b0; lock_clear = 1'b1;
    tick();
    pll_lock = 1'b1;
    tick_n(2);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL loss_state: got %0d want 0", state); end
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL loss_sys_reset: got %b want 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready: got %b want 0", ready); end
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL loss_pll_resetb: got %b want 0", pll_resetb); end
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_set_beats_clear: got %b want 1", lock_lost); end
    lock_clear = 1'b0;
    tick();
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_sticky: got %b want 1", lock_lost); end
    lock_clear = 1'b1;
    tick();
    lock_clear = 1'b0;
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_clear: got %b want 0", lock_lost); end
    wait_state(2'd3, 40);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL loss_recover_state: got %0d want 3", state); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_recover_ready: got %b want 1", ready); end
  endtask

  task automatic test_settle_glitch();
    pll_lock = 1'b1;
    pulse_reset();
    wait_state(2'd2, 30);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_enter_settle: got %0d want 2", state); end
    tick_n(3);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_still_settle: got %0d want 2", state); end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_back_waitlock: got %0d want 1", state); end
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_resettle: got %0d want 2", state); end
    tick_n(7);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_settle_full: got %0d want 2", state); end
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL glitch_run: got %0d want 3", state); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL glitch_retry: got %0d want 0", retry_count); end
  endtask

  task automatic test_timeout_retries();
    pll_lock = 1'b0;
    pulse_reset();
    tick_n(100);
    pll_lock = 1'b1;
    checks++; if (retry_count !== 8'd2) begin errors++; $display("FAIL timeout_retry_at_100: got %0d want 2", retry_count); end
    wait_state(2'd3, 40);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL timeout_run: got %0d want 3", state); end
    checks++; if (retry_count !== 8'd2) begin errors++; $display("FAIL timeout_retry_final: got %0d want 2", retry_count); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL timeout_lock_lost: got %b want 0", lock_lost); end
  endtask

  task automatic test_saturation();
    pll_lock = 1'b0;
    pulse_reset();
    tick_n(361);
    checks++; if (retry_count !== 8'd10) begin errors++; $display("FAIL sat_retry_10: got %0d want 10", retry_count); end
    tick_n(300 * 36 - 361 + 5);
    checks++; if (retry_count !== 8'd255) begin errors++; $display("FAIL sat_retry_255: got %0d want 255", retry_count); end
    tick_n(72);
    checks++; if (retry_count !== 8'd255) begin errors++; $display("FAIL sat_retry_hold: got %0d want 255", retry_count); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sat_ready: got %b want 0", ready); end
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL sat_sys_reset: got %b want 1", sys_reset); end
  endtask

  task automatic test_async_reset();
    pll_lock = 1'b1;
    pulse_reset();
    wait_state(2'd3, 40);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL async_pre_run: got %0d want 3", state); end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d want 0", state); end
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL async_pll_resetb: got %b want 0", pll_resetb); end
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL async_sys_reset: got %b want 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b want 0", ready); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL async_lock_lost: got %b want 0", lock_lost); end
    tick_n(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pll_lock = 1'b1; lock_clear = 1'b0;
    test_reset();
    test_lock_up();
    test_lock_loss();
    test_settle_glitch();
    test_timeout_retries();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
